// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a LANES x LANES systolic array: lane i of each beat is delayed i cycles.
// Define SYSTOLIC_FEEDER_BUBBLE_CNT_EN to add the saturating 16-bit bubble_cnt output.
module systolic_feeder #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned WORD    = 8,
  parameter int unsigned K_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WORD-1:0]  in_a,
  input  logic [LANES*WORD-1:0]  in_b,
  output logic [LANES*WORD-1:0]  a_out,
  output logic [LANES*WORD-1:0]  b_out,
  output logic                   busy,
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  output logic [15:0]            bubble_cnt,
`endif
  output logic                   tile_done
);

  localparam int unsigned BeatW  = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int unsigned DrainW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BeatW-1:0]  BeatLast  = BeatW'(K_DEPTH - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e              state_q;
  logic [BeatW-1:0]    beat_q;
  logic [DrainW-1:0]   drain_q;
  logic [LANES*WORD-1:0] stage_a, stage_b;

  assign in_ready  = (state_q == StStream);
  assign busy      = (state_q != StIdle);
  assign tile_done = (state_q == StDone);

  // Anything other than an accepted beat injects zeros into the skew line.
  assign stage_a = (in_ready && in_valid) ? in_a : '0;
  assign stage_b = (in_ready && in_valid) ? in_b : '0;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          beat_q  <= '0;
          drain_q <= '0;
          if (start) state_q <= StStream;
        end
        StStream: begin
          if (in_valid) begin
            if (beat_q == BeatLast) begin
              beat_q  <= '0;
              state_q <= StDrain;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            drain_q <= '0;
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WORD-1:0] a_sr [0:i];
    logic [WORD-1:0] b_sr [0:i];

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        for (int j = 0; j <= i; j++) begin
          a_sr[j] <= '0;
          b_sr[j] <= '0;
        end
      end else begin
        a_sr[0] <= stage_a[i*WORD +: WORD];
        b_sr[0] <= stage_b[i*WORD +: WORD];
        for (int j = 1; j <= i; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
        end
      end
    end

    assign a_out[i*WORD +: WORD] = a_sr[i];
    assign b_out[i*WORD +: WORD] = b_sr[i];
  end

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      bubble_q <= '0;
    end else if (state_q == StIdle && start) begin
      bubble_q <= '0;
    end else if (state_q == StStream && !in_valid && bubble_q != 16'hFFFF) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: skew timing, bubbles, ignored starts, reset, back-to-back tiles.
module tb_systolic_feeder;

  localparam int LANES = 4;
  localparam int WORD  = 8;
  localparam int K     = 8;
  localparam int W     = LANES * WORD;

  logic         clk = 1'b0;
  logic         clear_n, start, in_valid;
  logic [W-1:0] in_a, in_b, a_out, b_out;
  logic         in_ready, busy, tile_done;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  logic [15:0]  bubble_cnt;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.LANES(LANES), .WORD(WORD), .K_DEPTH(K)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .a_out      (a_out),
    .b_out      (b_out),
    .busy       (busy),
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .tile_done  (tile_done)
  );

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  logic         start2, valid2, ready2, busy2, done2;
  logic [W-1:0] a2_out, b2_out;
  logic [W-1:0] zero_w = '0;
  logic [15:0]  bubble_cnt2;

  systolic_feeder #(.LANES(LANES), .WORD(WORD), .K_DEPTH(1)) dut2 (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start2),
    .in_valid   (valid2),
    .in_ready   (ready2),
    .in_a       (zero_w),
    .in_b       (zero_w),
    .a_out      (a2_out),
    .b_out      (b2_out),
    .busy       (busy2),
    .bubble_cnt (bubble_cnt2),
    .tile_done  (done2)
  );
`endif

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [W-1:0] ha[$];
  logic [W-1:0] hb[$];

  always @(negedge clk) if (tile_done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int mode, input int k, input bit is_b);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      if (mode == 0) v[i*WORD +: WORD] = is_b ? 8'(8'h20 + i) : 8'(8'h10 + i);
      else           v[i*WORD +: WORD] = is_b ? 8'(8'h80 + k*8 + i) : 8'(k*16 + i + mode);
    end
    return v;
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    ha.push_back(a);
    hb.push_back(b);
  endtask

  // Lane i shows what entered stage 0 i edges before the latest one.
  task automatic check_outs(input string tag);
    logic [W-1:0] ea, eb;
    for (int i = 0; i < LANES; i++) begin
      ea[i*WORD +: WORD] = ha[ha.size()-1-i][i*WORD +: WORD];
      eb[i*WORD +: WORD] = hb[hb.size()-1-i][i*WORD +: WORD];
    end
    chk({tag, ":a_out"}, a_out, ea);
    chk({tag, ":b_out"}, b_out, eb);
  endtask

  // st: expected state after the edge (0 idle, 1 stream, 2 drain, 3 done)
  task automatic step(input logic [W-1:0] ea, input logic [W-1:0] eb, input int st,
                      input string tag);
    @(posedge clk); #1;
    push(ea, eb);
    check_outs(tag);
    chk({tag, ":busy"}, busy, st != 0);
    chk({tag, ":in_ready"}, in_ready, st == 1);
    chk({tag, ":tile_done"}, tile_done, st == 3);
  endtask

  task automatic tile(input int mode, input int bub_at, input int nbub, input string tag);
    int d0;
    d0 = done_seen;
    start = 1'b1;
    step('0, '0, 1, {tag, ":start"});
    for (int k = 0; k < K; k++) begin
      start = (k == 2);
      if (k == bub_at) begin
        for (int j = 0; j < nbub; j++) begin
          in_valid = 1'b0;
          in_a = mk(mode, 50 + j, 0);
          in_b = mk(mode, 50 + j, 1);
          step('0, '0, 1, {tag, ":bubble"});
        end
      end
      in_valid = 1'b1;
      in_a = mk(mode, k, 0);
      in_b = mk(mode, k, 1);
      step(in_a, in_b, (k == K - 1) ? 2 : 1, {tag, ":beat"});
      if (mode == 0 && k == 2) chk({tag, ":lane3_early"}, a_out[W-1 -: WORD], 8'h00);
      if (mode == 0 && k == 3) chk({tag, ":lane3_first"}, a_out[W-1 -: WORD], 8'h13);
    end
    start = 1'b0;
    in_valid = 1'b0;
    in_a = mk(mode, 99, 0);
    in_b = mk(mode, 99, 1);
    for (int d = 0; d < LANES; d++) step('0, '0, (d == LANES - 1) ? 3 : 2, {tag, ":drain"});
    @(negedge clk); #1;
    chk({tag, ":done_count"}, done_seen, d0 + 1);
  endtask

  initial begin
    int d0;
    clear_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    start2 = 1'b0;
    valid2 = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) push('0, '0);

    #2 clear_n = 1'b0;
    #1;
    chk("rst:a_out", a_out, '0);
    chk("rst:b_out", b_out, '0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:in_ready", in_ready, 1'b0);
    chk("rst:tile_done", tile_done, 1'b0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    step('0, '0, 0, "idle");

    // Basic tile with constant lane data; stray start pulsed mid-stream.
    tile(0, -1, 0, "basic");

    // start held through DONE (ignored) and into IDLE: back-to-back tile.
    start = 1'b1;
    step('0, '0, 0, "b2b_idle");
    tile(1, -1, 0, "b2b");
    step('0, '0, 0, "idle2");

    tile(2, 4, 3, "bubble");
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, 16'd3);
`endif
    step('0, '0, 0, "idle3");

    // Reset after the fifth beat.
    d0 = done_seen;
    start = 1'b1;
    step('0, '0, 1, "rm:start");
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a = mk(3, k, 0);
      in_b = mk(3, k, 1);
      step(in_a, in_b, 1, "rm:beat");
    end
    clear_n = 1'b0;
    #1;
    chk("rm:a_out", a_out, '0);
    chk("rm:b_out", b_out, '0);
    chk("rm:busy", busy, 1'b0);
    chk("rm:in_ready", in_ready, 1'b0);
    chk("rm:tile_done", tile_done, 1'b0);
    for (int i = 0; i < LANES; i++) push('0, '0);
    @(posedge clk); #1;
    chk("rm:held_a", a_out, '0);
    chk("rm:held_busy", busy, 1'b0);
    clear_n = 1'b1;
    in_valid = 1'b0;
    step('0, '0, 0, "rm:idle");
    chk("rm:no_done", done_seen, d0);
    tile(4, -1, 0, "after_rst");

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    valid2 = 1'b0;
    chk("sat:cleared", bubble_cnt2, 16'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat:near", bubble_cnt2, 16'hFFFE);
    repeat (4466) @(posedge clk);
    #1;
    chk("sat:held", bubble_cnt2, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
